// File: rtl/dec_nx2n_pipe_pkg.sv
// Shared types and helpers for the N-to-2^N pipelined decoder (dec_nx2n_pipe).
package dec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SWEEP = 2'd2,
        DONE  = 2'd3
    } bist_state_t;

    localparam int MAX_W = 256;

    // Reference one-hot at the widest supported size; callers truncate to 2**N.
    function automatic logic [MAX_W-1:0] onehot(input logic [7:0] code, input logic en);
        logic [MAX_W-1:0] v;
        v = '0;
        if (en) v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dec_nx2n_pipe_if.sv
// Producer/consumer handshake bundle for dec_nx2n_pipe.
interface dec_nx2n_pipe_if #(
    parameter int N = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      in_code;
    logic              in_en;
    logic              out_valid;
    logic              out_ready;
    logic [2**N-1:0]   out_d;

    modport master (
        output in_valid, in_code, in_en, out_ready,
        input  in_ready, out_valid, out_d
    );

    modport slave (
        input  in_valid, in_code, in_en, out_ready,
        output in_ready, out_valid, out_d
    );
endinterface

// File: rtl/dec_nx2n_pipe_core.sv
// Combinational N -> 2**N decoder with enable and single-bit stuck-at overlay.
module dec_core
    import dec_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]    code,
    input  logic            en,
    input  logic            fault_en,
    input  logic [N-1:0]    fault_idx,
    input  logic            fault_val,
    output logic [2**N-1:0] dec
);
    localparam int W = 2**N;

    always_comb begin
        dec = W'(onehot(8'(code), en));
        if (fault_en) dec[fault_idx] = fault_val;
    end
endmodule

// File: rtl/dec_nx2n_pipe.sv
// Registered one-hot decoder with valid/ready handshake and on-demand BIST sweep.
// Optional macro FAULT_INJECT_EN adds fault_* ports that force one decoded bit.
//
// state | meaning
// IDLE  | normal decoding, accepts input, watches bist_start
// WAIT  | BIST requested, input blocked, waiting for consumer to drain out_d
// SWEEP | checking every code 0..2**N-1 on the BIST decoder copy
// DONE  | one-cycle bist_done pulse, result already latched
module dec_nx2n_pipe
    import dec_pkg::*;
#(
    parameter int N       = 4,
    parameter bit BIST_EN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    dec_nx2n_pipe_if.slave bus,
    input  logic bist_start,
    output logic bist_busy,
    output logic bist_done,
    output logic bist_pass
`ifdef FAULT_INJECT_EN
    ,
    input  logic         fault_en,
    input  logic [N-1:0] fault_idx,
    input  logic         fault_val
`endif
);
    localparam int W = 2**N;

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_WAIT  = 2'(WAIT);
    localparam logic [1:0] ST_SWEEP = 2'(SWEEP);
    localparam logic [1:0] ST_DONE  = 2'(DONE);

    logic         f_en;
    logic [N-1:0] f_idx;
    logic         f_val;

`ifdef FAULT_INJECT_EN
    assign f_en  = fault_en;
    assign f_idx = fault_idx;
    assign f_val = fault_val;
`else
    assign f_en  = 1'b0;
    assign f_idx = '0;
    assign f_val = 1'b0;
`endif

    logic [1:0]   state;
    logic [N-1:0] cnt;
    logic         fail;
    logic         pass_r;
    logic         out_valid_r;
    logic [W-1:0] out_d_r;
    logic [W-1:0] dec_fn;
    logic [W-1:0] dec_bist;
    logic [W-1:0] exp_bist;
    logic         start_req;
    logic         take;
    logic         sweep_bad;

    dec_core #(.N(N)) u_dec_fn (
        .code      (bus.in_code),
        .en        (bus.in_en),
        .fault_en  (f_en),
        .fault_idx (f_idx),
        .fault_val (f_val),
        .dec       (dec_fn)
    );

    dec_core #(.N(N)) u_dec_bist (
        .code      (cnt),
        .en        (1'b1),
        .fault_en  (f_en),
        .fault_idx (f_idx),
        .fault_val (f_val),
        .dec       (dec_bist)
    );

    // A start request wins over a same-cycle input, so it also drops in_ready.
    assign start_req    = BIST_EN && bist_start && (state == ST_IDLE);
    assign bus.in_ready = (state == ST_IDLE) && !start_req && (!out_valid_r || bus.out_ready);
    assign take         = bus.in_valid && bus.in_ready;

    assign exp_bist  = W'(1) << cnt;
    assign sweep_bad = (dec_bist != exp_bist);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_d_r     <= '0;
        end else if (take) begin
            out_valid_r <= 1'b1;
            out_d_r     <= dec_fn;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_d     = out_d_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            fail   <= 1'b0;
            pass_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state  <= ST_WAIT;
                        pass_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (!out_valid_r) begin
                        state <= ST_SWEEP;
                        cnt   <= '0;
                        fail  <= 1'b0;
                    end
                end
                ST_SWEEP: begin
                    fail <= fail | sweep_bad;
                    cnt  <= cnt + 1'b1;
                    // Latch the verdict with the last code so it is visible alongside bist_done.
                    if (cnt == '1) begin
                        state  <= ST_DONE;
                        pass_r <= !(fail | sweep_bad);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bist_busy = (state == ST_WAIT) || (state == ST_SWEEP);
    assign bist_done = (state == ST_DONE);
    assign bist_pass = pass_r;
endmodule

// File: tb/tb_dec_nx2n_pipe.sv
// Self-checking bench for dec_nx2n_pipe (N=4): directed handshake cases, random stream, BIST.
module tb_dec_nx2n_pipe;
    localparam int N = 4;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    logic bist_start, bist_busy, bist_done, bist_pass;
`ifdef FAULT_INJECT_EN
    logic         fault_en;
    logic [N-1:0] fault_idx;
    logic         fault_val;
`endif

    int total = 0;
    int bad   = 0;

    logic         mv;
    logic [W-1:0] md;

    always #5 clk = ~clk;

    dec_nx2n_pipe_if #(.N(N)) bus ();

    dec_nx2n_pipe #(.N(N), .BIST_EN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .bist_start (bist_start),
        .bist_busy  (bist_busy),
        .bist_done  (bist_done),
        .bist_pass  (bist_pass)
`ifdef FAULT_INJECT_EN
        ,
        .fault_en   (fault_en),
        .fault_idx  (fault_idx),
        .fault_val  (fault_val)
`endif
    );

    function automatic logic [W-1:0] ref_dec(input int code, input bit en);
        return en ? W'(32'd1 << code) : '0;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.in_code = 4'd7; bus.in_en = 1'b1; bus.out_ready = 1'b0;
        bist_start = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_d !== 16'h0000)
            begin bad++; $display("FAIL reset_out: got v=%b d=%h want v=0 d=0000", bus.out_valid, bus.out_d); end
        total++;
        if (bist_busy !== 1'b0 || bist_done !== 1'b0 || bist_pass !== 1'b0)
            begin bad++; $display("FAIL reset_bist: got busy=%b done=%b pass=%b want 0 0 0", bist_busy, bist_done, bist_pass); end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        mv = 1'b0; md = '0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        bus.in_valid = 1'b1; bus.in_code = 4'd5; bus.in_en = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_d !== 16'h0020)
            begin bad++; $display("FAIL code5: got v=%b d=%h want v=1 d=0020", bus.out_valid, bus.out_d); end
        bus.out_ready = 1'b0; bus.in_code = 4'd9;
        #1;
        total++;
        if (bus.in_ready !== 1'b0)
            begin bad++; $display("FAIL stall_ready: got %b want 0", bus.in_ready); end
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_d !== 16'h0020)
            begin bad++; $display("FAIL stall_hold: got v=%b d=%h want v=1 d=0020", bus.out_valid, bus.out_d); end
        bus.out_ready = 1'b1; bus.in_code = 4'd15; bus.in_en = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b1)
            begin bad++; $display("FAIL drain_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_d !== 16'h0000)
            begin bad++; $display("FAIL en0: got v=%b d=%h want v=1 d=0000", bus.out_valid, bus.out_d); end
        bus.in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0)
            begin bad++; $display("FAIL clear_valid: got %b want 0", bus.out_valid); end
        mv = 1'b0; md = '0;
    endtask

    task automatic test_random_stream(input int cycles, input bit full_rate);
        bit exp_ready;
        bit tk;
        for (int i = 0; i < cycles; i++) begin
            bus.in_valid  = full_rate ? 1'b1 : 1'($urandom_range(0, 1));
            bus.in_code   = 4'($urandom_range(0, 15));
            bus.in_en     = ($urandom_range(0, 3) != 0);
            bus.out_ready = full_rate ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            exp_ready = !mv || bus.out_ready;
            total++;
            if (bus.in_ready !== exp_ready)
                begin bad++; $display("FAIL stream_ready[%0d]: got %b want %b", i, bus.in_ready, exp_ready); end
            tk = bus.in_valid && exp_ready;
            @(negedge clk);
            if (tk) begin
                md = ref_dec(int'(bus.in_code), bus.in_en);
                mv = 1'b1;
            end else if (bus.out_ready) begin
                mv = 1'b0;
            end
            total++;
            if (bus.out_valid !== mv || bus.out_d !== md)
                begin bad++; $display("FAIL stream_out[%0d]: got v=%b d=%h want v=%b d=%h", i, bus.out_valid, bus.out_d, mv, md); end
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        mv = 1'b0;
    endtask

    // Counts busy cycles from the current negedge until bist_busy falls; checks that
    // no input sneaks through and that the done pulse / verdict appear together.
    task automatic run_bist_to_done(input int exp_busy, input bit exp_pass, input string tag);
        int n = 0;
        while (bist_busy === 1'b1 && n < 200) begin
            total++;
            if (bus.in_ready !== 1'b0 || bist_done !== 1'b0)
                begin bad++; $display("FAIL %s_busy_cycle[%0d]: got ready=%b done=%b want 0 0", tag, n, bus.in_ready, bist_done); end
            n++;
            @(negedge clk);
        end
        total++;
        if (n !== exp_busy)
            begin bad++; $display("FAIL %s_busy_len: got %0d want %0d", tag, n, exp_busy); end
        total++;
        if (bist_done !== 1'b1 || bist_pass !== exp_pass)
            begin bad++; $display("FAIL %s_done: got done=%b pass=%b want done=1 pass=%b", tag, bist_done, bist_pass, exp_pass); end
        total++;
        if (bus.out_valid !== mv || bus.out_d !== md)
            begin bad++; $display("FAIL %s_out_untouched: got v=%b d=%h want v=%b d=%h", tag, bus.out_valid, bus.out_d, mv, md); end
        @(negedge clk);
        total++;
        if (bist_done !== 1'b0 || bist_pass !== exp_pass)
            begin bad++; $display("FAIL %s_after: got done=%b pass=%b want done=0 pass=%b", tag, bist_done, bist_pass, exp_pass); end
    endtask

    task automatic test_bist_clean();
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bist_start = 1'b1;
        @(negedge clk);
        bist_start = 1'b0;
        // One WAIT cycle (nothing to drain) followed by a 16-code sweep.
        run_bist_to_done(17, 1'b1, "bist_clean");
    endtask

    task automatic test_bist_wait();
        int code;
        code = int'($urandom_range(0, 15));
        bus.in_valid = 1'b1; bus.in_code = 4'(code); bus.in_en = 1'b1; bus.out_ready = 1'b0;
        @(negedge clk);
        md = ref_dec(code, 1'b1); mv = 1'b1;
        bus.in_valid = 1'b0; bist_start = 1'b1;
        @(negedge clk);
        bist_start = 1'b0;
        bus.in_valid = 1'b1; bus.in_code = 4'((code + 1) % 16);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (bist_busy !== 1'b1 || bist_pass !== 1'b0 || bus.in_ready !== 1'b0)
                begin bad++; $display("FAIL wait_hold[%0d]: got busy=%b pass=%b ready=%b want 1 0 0", i, bist_busy, bist_pass, bus.in_ready); end
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_d !== md)
                begin bad++; $display("FAIL wait_out[%0d]: got v=%b d=%h want v=1 d=%h", i, bus.out_valid, bus.out_d, md); end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        mv = 1'b0;
        // Still WAIT on this cycle, then the full sweep; in_valid stays high throughout.
        run_bist_to_done(17, 1'b1, "bist_wait");
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_sweep();
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bist_start = 1'b1;
        @(negedge clk);
        bist_start = 1'b0;
        repeat (7) @(negedge clk);
        bist_start = 1'b1;
        @(negedge clk);
        bist_start = 1'b0;
        total++;
        if (bist_busy !== 1'b1)
            begin bad++; $display("FAIL restart_ignored: got busy=%b want 1", bist_busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mv = 1'b0; md = '0;
        total++;
        if (bist_busy !== 1'b0 || bist_done !== 1'b0 || bist_pass !== 1'b0)
            begin bad++; $display("FAIL mid_reset: got busy=%b done=%b pass=%b want 0 0 0", bist_busy, bist_done, bist_pass); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (bist_done !== 1'b0 || bist_busy !== 1'b0)
                begin bad++; $display("FAIL no_done_after_reset[%0d]: got done=%b busy=%b want 0 0", i, bist_done, bist_busy); end
        end
    endtask

`ifdef FAULT_INJECT_EN
    task automatic test_fault();
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        fault_en = 1'b1; fault_idx = 4'd3; fault_val = 1'b1;
        bist_start = 1'b1;
        @(negedge clk);
        bist_start = 1'b0;
        run_bist_to_done(17, 1'b0, "fault_sa1");
        bus.in_valid = 1'b1; bus.in_code = 4'd0; bus.in_en = 1'b1;
        @(negedge clk);
        total++;
        if (bus.out_d !== 16'h0009)
            begin bad++; $display("FAIL fault_code0: got %h want 0009", bus.out_d); end
        fault_idx = 4'd6; fault_val = 1'b0; bus.in_code = 4'd6;
        @(negedge clk);
        total++;
        if (bus.out_d !== 16'h0000)
            begin bad++; $display("FAIL fault_sa0: got %h want 0000", bus.out_d); end
        fault_en = 1'b0;
        @(negedge clk);
        total++;
        if (bus.out_d !== 16'h0040)
            begin bad++; $display("FAIL fault_off: got %h want 0040", bus.out_d); end
        bus.in_valid = 1'b0;
        @(negedge clk);
        mv = 1'b0; md = 16'h0040;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_code = '0; bus.in_en = 1'b0; bus.out_ready = 1'b0;
        bist_start = 1'b0; rst = 1'b1;
`ifdef FAULT_INJECT_EN
        fault_en = 1'b0; fault_idx = '0; fault_val = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_directed();
        test_random_stream(300, 1'b0);
        test_random_stream(40, 1'b1);
        test_bist_clean();
        test_bist_wait();
        test_random_stream(50, 1'b0);
        test_reset_mid_sweep();
`ifdef FAULT_INJECT_EN
        test_fault();
`endif
        test_random_stream(50, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
